// File: rtl/link_master_fsm.sv
// Initiator side of a 4-phase req/ack byte link: sends a burst of BURST_LEN
// consecutive bytes, one per full handshake, with a per-phase ack timeout.
module link_master_fsm #(
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] base_byte,
    input  logic       ack,
    output logic       req,
    output logic [7:0] data_out,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] byte_idx
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] DRIVE   = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    localparam int             CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [7:0]     LAST_IDX = 8'(BURST_LEN - 1);

    logic [1:0]    state;
    logic [CW-1:0] count;
    logic [7:0]    base;

    assign busy = (state != IDLE);

    // The count restarts on every phase entry, so each handshake phase gets
    // its own TIMEOUT-cycle budget before the burst is abandoned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            base     <= 8'h00;
            req      <= 1'b0;
            data_out <= 8'h00;
            done     <= 1'b0;
            err      <= 1'b0;
            byte_idx <= 8'h00;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base     <= base_byte;
                        data_out <= base_byte;
                        req      <= 1'b1;
                        byte_idx <= 8'h00;
                        err      <= 1'b0;
                        count    <= '0;
                        state    <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (ack) begin
                        req   <= 1'b0;
                        count <= '0;
                        state <= RELEASE;
                    end else if (count == CNT_LAST) begin
                        req   <= 1'b0;
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                RELEASE: begin
                    // Next byte is launched only once ack is seen low again.
                    if (!ack) begin
                        if (byte_idx == LAST_IDX) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            byte_idx <= byte_idx + 8'd1;
                            data_out <= base + byte_idx + 8'd1;
                            req      <= 1'b1;
                            count    <= '0;
                            state    <= DRIVE;
                        end
                    end else if (count == CNT_LAST) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    req   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_link_master_fsm.sv
// Bench for link_master_fsm: behavioural slave with a byte scoreboard, a table
// of burst scenarios, and hand-written sequences for start/done and reset corners.
module tb_link_master_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] base_byte = 8'h00;
    logic       ack = 1'b0;
    logic       req;
    logic [7:0] data_out;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] byte_idx;

    link_master_fsm #(.BURST_LEN(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start), .base_byte(base_byte), .ack(ack),
        .req(req), .data_out(data_out), .busy(busy), .done(done), .err(err),
        .byte_idx(byte_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] base;
        int         mode;       // 0 normal slave, 1 ack stuck low, 2 ack stuck high after first byte
        int         exp_err;
        int         exp_done;
        int         exp_bytes;
        int         exp_idx;
        int         exp_req_high;
    } vec_t;

    vec_t       vecs[5];
    logic [7:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         captured = 0;
    int         done_cnt = 0;
    int         req_high = 0;
    int         slave_mode = 0;
    int         slave_cnt = 0;
    bit         stuck = 1'b0;
    logic       prev_req = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    // Protocol monitor runs before the slave so it sees ack as the DUT sampled it.
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst) begin
            ack       = 1'b0;
            slave_cnt = 0;
            stuck     = 1'b0;
            prev_req  = 1'b0;
            prev_data = 8'h00;
        end else begin
            if (req && !prev_req) begin
                checkOutput("req_rise_with_ack_low", int'(ack), 0);
                captured++;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_byte", int'(data_out), -1);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("byte_value", int'(data_out), int'(e));
                end
            end
            if (req && prev_req)
                checkOutput("data_stable_while_req", int'(data_out), int'(prev_data));
            if (req)
                req_high++;
            if (done) begin
                done_cnt++;
                checkOutput("busy_low_in_done_cycle", int'(busy), 0);
            end
            prev_req  = req;
            prev_data = data_out;

            if (slave_mode != 2)
                stuck = 1'b0;
            case (slave_mode)
                1: ack = 1'b0;
                default: begin
                    if (req && !ack && !stuck) begin
                        slave_cnt++;
                        if (slave_cnt == 2) begin
                            ack       = 1'b1;
                            slave_cnt = 0;
                            if (slave_mode == 2)
                                stuck = 1'b1;
                        end
                    end else if (!req && ack && !stuck) begin
                        ack = 1'b0;
                    end
                end
            endcase
        end
    end

    task automatic waitIdle(input string name);
        int n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: busy still %0d after %0d cycles, required 0", name, busy, n);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int mode, input int nbytes);
        logic [7:0] v;
        @(negedge clk);
        slave_mode = mode;
        @(negedge clk);
        @(negedge clk);
        captured = 0;
        done_cnt = 0;
        req_high = 0;
        for (int i = 0; i < nbytes; i++) begin
            v = b + 8'(i);
            exp_q.push_back(v);
        end
        start     = 1'b1;
        base_byte = b;
        @(negedge clk);
        start     = 1'b0;
        base_byte = 8'h00;
        waitIdle("burst");
        @(negedge clk);
    endtask

    initial begin
        int n;
        logic [7:0] v;

        vecs[0] = '{8'h10, 0, 0, 1, 4, 3, 8};
        vecs[1] = '{8'hFE, 0, 0, 1, 4, 3, 8};
        vecs[2] = '{8'h55, 1, 1, 0, 1, 0, 16};
        vecs[3] = '{8'h20, 0, 0, 1, 4, 3, 8};
        vecs[4] = '{8'h30, 2, 1, 0, 1, 0, 2};

        #1 rst = 1'b1;
        #3;
        checkOutput("reset_req", int'(req), 0);
        checkOutput("reset_data_out", int'(data_out), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_err", int'(err), 0);
        checkOutput("reset_byte_idx", int'(byte_idx), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            $display("[TB] vector %0d base 0x%0h mode %0d", i, vecs[i].base, vecs[i].mode);
            applyStimulus(vecs[i].base, vecs[i].mode, vecs[i].exp_bytes);
            checkOutput($sformatf("v%0d_err", i), int'(err), vecs[i].exp_err);
            checkOutput($sformatf("v%0d_done_count", i), done_cnt, vecs[i].exp_done);
            checkOutput($sformatf("v%0d_bytes_issued", i), captured, vecs[i].exp_bytes);
            checkOutput($sformatf("v%0d_byte_idx", i), int'(byte_idx), vecs[i].exp_idx);
            checkOutput($sformatf("v%0d_scoreboard_left", i), exp_q.size(), 0);
            checkOutput($sformatf("v%0d_req_high_cycles", i), req_high, vecs[i].exp_req_high);
            checkOutput($sformatf("v%0d_busy", i), int'(busy), 0);
        end

        // Repeated start during a burst, then a start accepted in the done cycle.
        $display("[TB] sequence: start pulses during burst, restart in done cycle");
        @(negedge clk);
        slave_mode = 0;
        @(negedge clk);
        @(negedge clk);
        captured = 0;
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            v = 8'h40 + 8'(i);
            exp_q.push_back(v);
        end
        start     = 1'b1;
        base_byte = 8'h40;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 400) begin
            start     = ~start;
            base_byte = 8'($urandom);
            @(negedge clk);
            n++;
        end
        checkOutput("pulse_burst_ended", int'(busy), 0);
        checkOutput("done_at_idle_entry", int'(done), 1);
        checkOutput("pulse_burst_scoreboard_left", exp_q.size(), 0);
        for (int i = 0; i < 4; i++) begin
            v = 8'h50 + 8'(i);
            exp_q.push_back(v);
        end
        start     = 1'b1;
        base_byte = 8'h50;
        @(negedge clk);
        start     = 1'b0;
        base_byte = 8'h00;
        checkOutput("restart_req", int'(req), 1);
        checkOutput("restart_data_out", int'(data_out), 8'h50);
        checkOutput("restart_busy", int'(busy), 1);
        waitIdle("restart");
        @(negedge clk);
        checkOutput("restart_done_count", done_cnt, 2);
        checkOutput("restart_bytes_issued", captured, 8);
        checkOutput("restart_scoreboard_left", exp_q.size(), 0);
        checkOutput("restart_err", int'(err), 0);

        // Asynchronous reset while byte 2 is being driven.
        $display("[TB] sequence: reset during DRIVE of byte 2");
        captured = 0;
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            v = 8'h60 + 8'(i);
            exp_q.push_back(v);
        end
        start     = 1'b1;
        base_byte = 8'h60;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(req && byte_idx == 8'd2) && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reached_byte2_drive", int'(req && byte_idx == 8'd2), 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_reset_req", int'(req), 0);
        checkOutput("async_reset_busy", int'(busy), 0);
        checkOutput("async_reset_data_out", int'(data_out), 0);
        checkOutput("async_reset_byte_idx", int'(byte_idx), 0);
        checkOutput("bytes_before_reset", captured, 3);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("no_done_after_reset", done_cnt, 0);

        applyStimulus(8'hA0, 0, 4);
        checkOutput("post_reset_err", int'(err), 0);
        checkOutput("post_reset_done_count", done_cnt, 1);
        checkOutput("post_reset_bytes_issued", captured, 4);
        checkOutput("post_reset_byte_idx", int'(byte_idx), 3);
        checkOutput("post_reset_scoreboard_left", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
